coproc_issuer: RTL

Host-side initiator for the GCD/LCM coprocessor's Start/WriteData/ReadData handshake. It queues operation requests from the core in a small FIFO and issues each one to the coprocessor. For each operation it holds Start until the done bit is returned, captures the 8-bit result, releases Start, and waits for done to clear before the next issue. Results go back to the core on a valid/ready response channel, with a timeout error for a coprocessor that never completes.

---
 rtl/coproc_pkg.sv | 38 +++
 rtl/coproc_req_fifo.sv | 63 ++++++
 rtl/coproc_issuer.sv | 114 +++++++++++
 3 files changed

// File: rtl/coproc_pkg.sv
// Shared types and field positions for the GCD/LCM coprocessor handshake.
// A request is packed as {op, b, a} so it maps directly onto the low WriteData bits.
package coproc_pkg;

    typedef enum logic {
        GCD = 1'b0,
        LCM = 1'b1
    } op_e;

    localparam int WD_A_LSB    = 0;
    localparam int WD_B_LSB    = 8;
    localparam int WD_OP_BIT   = 16;
    localparam int RD_DONE_BIT = 8;
    localparam int RD_RES_MSB  = 7;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE,
        RESP
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [7:0] b;
        logic [7:0] a;
    } req_t;

    function automatic logic [31:0] pack_wd(input req_t r);
        logic [31:0] wd;
        wd                   = '0;
        wd[WD_A_LSB +: 8]    = r.a;
        wd[WD_B_LSB +: 8]    = r.b;
        wd[WD_OP_BIT]        = r.op;
        return wd;
    endfunction

endpackage

// File: rtl/coproc_req_fifo.sv
// Show-ahead request FIFO with registered full/empty/dout.
// Pointers carry one extra wrap bit to tell full from empty.
module coproc_req_fifo
    import coproc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  req_t din,
    output req_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    req_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr_n;
    logic [AW:0]   rd_ptr_n;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every always_comb output gets an unconditional default first so no latch is inferred.
    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        if (do_push) wr_ptr_n = wr_ptr + 1'b1;
        if (do_pop)  rd_ptr_n = rd_ptr + 1'b1;
    end

    // NOTE: storage is left unreset; only pointers and flags define validity, which keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
            empty  <= (wr_ptr_n == rd_ptr_n);
            // Bypass when the entry being written becomes the new head.
            if (do_push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) dout <= din;
            else                                                  dout <= mem[rd_ptr_n[AW-1:0]];
        end
    end

endmodule

// File: rtl/coproc_issuer.sv
// Issues queued GCD/LCM requests over the Start/WriteData/ReadData handshake,
// one at a time, and returns results with a timeout error on a valid/ready channel.
module coproc_issuer
    import coproc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_result,
    output logic        rsp_err,
    output logic        Start,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state;
    logic [CW-1:0] cnt;
    req_t          req_in;
    req_t          fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          done;
    logic          cnt_last;
    logic          unused_rd_bits;

    assign req_in         = '{op: op_e'(req_op), b: req_b, a: req_a};
    assign req_ready      = !fifo_full;
    assign fifo_pop       = (state == IDLE) && !fifo_empty;
    assign done           = ReadData[RD_DONE_BIT];
    assign cnt_last       = (cnt == CNT_LAST);
    assign unused_rd_bits = ^ReadData[31:RD_DONE_BIT+1];

    coproc_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid),
        .pop   (fifo_pop),
        .din   (req_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            Start      <= 1'b0;
            WriteData  <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        WriteData <= pack_wd(fifo_dout);
                        Start     <= 1'b1;
                        cnt       <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (done) begin
                        rsp_result <= ReadData[RD_RES_MSB:0];
                        rsp_err    <= 1'b0;
                        Start      <= 1'b0;
                        cnt        <= '0;
                        state      <= RELEASE;
                    end else if (cnt_last) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        Start      <= 1'b0;
                        cnt        <= '0;
                        state      <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // A done that never clears is also reported as a timeout.
                    if (!done || cnt_last) begin
                        if (done) rsp_err <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
